// File: rtl/axis_frame_gen_if.sv
// AXI-stream handshake bundle between the frame generator and its consumer.
interface axis_frame_gen_if #(
    parameter int DSIZE = 8
);
    logic [DSIZE-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// Counter-pattern AXI-stream frame source with programmable length and gap.
// Optional trailer checksum beat enabled by AXIS_FRAME_GEN_CSUM_EN.
module axis_frame_gen #(
    parameter int DSIZE = 8,
    parameter int LSIZE = 10,
    parameter int GSIZE = 8
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [LSIZE-1:0]     frame_len,
    input  logic [GSIZE-1:0]     gap_len,
    axis_frame_gen_if.master     axis,
    output logic [15:0]          frame_cnt,
    output logic                 busy
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [LSIZE-1:0] len_r, len_s;
    logic [GSIZE-1:0] gap_r, gap_s;
    logic [LSIZE-1:0] idx_r, idx_s;
    logic [GSIZE-1:0] gap_cnt_r, gap_cnt_s;
    logic [DSIZE-1:0] tdata_r, tdata_s;
    logic             tvalid_r, tvalid_s;
    logic             tlast_r, tlast_s;
    logic [15:0]      frame_cnt_r, frame_cnt_s;
    logic             busy_r, busy_s;
    logic             hs_s;
`ifdef AXIS_FRAME_GEN_CSUM_EN
    logic [DSIZE-1:0] csum_r, csum_s;
    logic             trailer_r, trailer_s;

    function automatic logic [DSIZE-1:0] csum_step(input logic [DSIZE-1:0] acc,
                                                   input logic [DSIZE-1:0] beat);
        return acc ^ beat;
    endfunction
`endif

    assign hs_s = tvalid_r & axis.tready;

    // Next-state and next-output computation for every register.
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        gap_s       = gap_r;
        idx_s       = idx_r;
        gap_cnt_s   = gap_cnt_r;
        tdata_s     = tdata_r;
        tvalid_s    = tvalid_r;
        tlast_s     = tlast_r;
        frame_cnt_s = frame_cnt_r;
        busy_s      = busy_r;
`ifdef AXIS_FRAME_GEN_CSUM_EN
        csum_s      = csum_r;
        trailer_s   = trailer_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s  = ST_SEND;
                    len_s    = frame_len;
                    gap_s    = gap_len;
                    idx_s    = '0;
                    tdata_s  = DSIZE'(frame_cnt_r);
                    tvalid_s = 1'b1;
                    busy_s   = 1'b1;
`ifdef AXIS_FRAME_GEN_CSUM_EN
                    tlast_s   = 1'b0;
                    csum_s    = '0;
                    trailer_s = 1'b0;
`else
                    tlast_s  = (frame_len == '0);
`endif
                end else begin
                    tvalid_s = 1'b0;
                    tlast_s  = 1'b0;
                    busy_s   = 1'b0;
                end
            end
            ST_SEND: begin
                if (hs_s) begin
`ifdef AXIS_FRAME_GEN_CSUM_EN
                    if (trailer_r) begin
                        state_s     = ST_GAP;
                        tvalid_s    = 1'b0;
                        tlast_s     = 1'b0;
                        tdata_s     = '0;
                        gap_cnt_s   = '0;
                        trailer_s   = 1'b0;
                        frame_cnt_s = frame_cnt_r + 16'd1;
                    end else if (idx_r == len_r) begin
                        // Final payload beat accepted: present the folded checksum.
                        tdata_s   = csum_step(csum_r, tdata_r);
                        csum_s    = csum_step(csum_r, tdata_r);
                        tlast_s   = 1'b1;
                        trailer_s = 1'b1;
                    end else begin
                        idx_s   = idx_r + LSIZE'(1);
                        tdata_s = tdata_r + DSIZE'(1);
                        csum_s  = csum_step(csum_r, tdata_r);
                        tlast_s = 1'b0;
                    end
`else
                    if (idx_r == len_r) begin
                        state_s     = ST_GAP;
                        tvalid_s    = 1'b0;
                        tlast_s     = 1'b0;
                        tdata_s     = '0;
                        gap_cnt_s   = '0;
                        frame_cnt_s = frame_cnt_r + 16'd1;
                    end else begin
                        idx_s   = idx_r + LSIZE'(1);
                        tdata_s = tdata_r + DSIZE'(1);
                        tlast_s = ((idx_r + LSIZE'(1)) == len_r);
                    end
`endif
                end else begin
                    tvalid_s = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == gap_r) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    gap_cnt_s = gap_cnt_r + GSIZE'(1);
                end
            end
            default: begin
                state_s  = ST_IDLE;
                tvalid_s = 1'b0;
                tlast_s  = 1'b0;
                tdata_s  = '0;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            len_r       <= '0;
            gap_r       <= '0;
            idx_r       <= '0;
            gap_cnt_r   <= '0;
            tdata_r     <= '0;
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            frame_cnt_r <= 16'd0;
            busy_r      <= 1'b0;
`ifdef AXIS_FRAME_GEN_CSUM_EN
            csum_r      <= '0;
            trailer_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            gap_r       <= gap_s;
            idx_r       <= idx_s;
            gap_cnt_r   <= gap_cnt_s;
            tdata_r     <= tdata_s;
            tvalid_r    <= tvalid_s;
            tlast_r     <= tlast_s;
            frame_cnt_r <= frame_cnt_s;
            busy_r      <= busy_s;
`ifdef AXIS_FRAME_GEN_CSUM_EN
            csum_r      <= csum_s;
            trailer_r   <= trailer_s;
`endif
        end
    end

    assign axis.tdata  = tdata_r;
    assign axis.tvalid = tvalid_r;
    assign axis.tlast  = tlast_r;
    assign frame_cnt   = frame_cnt_r;
    assign busy        = busy_r;
endmodule
